// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: PC-source encodings, reset/bubble constants
// and jump-target helpers used by the fetch and decode stages.
package mips_pkg;

   // Decoder PCSrc encoding for the instruction currently in ID.
   typedef enum logic [1:0] {
      PCSRC_BRANCH = 2'b00,
      PCSRC_SEQ    = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_JR     = 2'b11
   } pcsrc_e;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;   // sll $0,$0,0

   // Pseudo-direct j/jal target: upper nibble of the delay-free PC+4.
   function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                             input logic [31:0] instr);
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

   function automatic logic [31:0] jr_target(input logic [31:0] rs_data);
      return {rs_data[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline stage register carrying instr / pc_plus4 / valid.
// Priority: reset, flush (bubble), hold, load (valid fetch).
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        hold,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_plus4_in,
   output logic [31:0] instr,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         instr    <= NOP_INSTR;
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (flush) begin
         instr    <= NOP_INSTR;
         pc_plus4 <= '0;
         valid    <= 1'b0;
      end else if (!hold) begin
         instr    <= instr_in;
         pc_plus4 <= pc_plus4_in;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and a saturating count of valid fetches.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned IMEM_AW   = 8,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               ex_branch_taken,
   input  logic [31:0]        ex_branch_target,
   input  logic [1:0]         id_pcsrc,
   input  logic [31:0]        id_rs_data,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        pc,
   output logic [31:0]        if_id_instr,
   output logic [31:0]        if_id_pc_plus4,
   output logic               if_id_valid,
   output logic [31:0]        fetch_count
);

   logic [31:0] pc_plus4;
   logic [31:0] jump_tgt;
   logic [31:0] next_pc;
   logic        id_jump;
   logic        ifid_flush;
   logic        ifid_load_valid;
   logic        unused;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc[IMEM_AW+1:2];
   assign id_jump   = if_id_valid & id_pcsrc[1];
   assign unused    = ^{id_rs_data[1:0], ex_branch_target[1:0]};

   always_comb begin
      jump_tgt = j_target(if_id_pc_plus4, if_id_instr);
      if (id_pcsrc == PCSRC_JR)
         jump_tgt = jr_target(id_rs_data);
   end

   // Stall outranks the ID jump so a jr never redirects on a stale rs value.
   always_comb begin
      next_pc = pc_plus4;
      if (ex_branch_taken)
         next_pc = word_align(ex_branch_target);
      else if (stall)
         next_pc = pc;
      else if (id_jump)
         next_pc = jump_tgt;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc <= RESET_PC;
      else
         pc <= next_pc;
   end

   // A branch flush drops a concurrent stall; a jump kills only when unstalled.
   assign ifid_flush      = ex_branch_taken | (!stall & id_jump);
   assign ifid_load_valid = !ex_branch_taken & !stall & !id_jump;

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk        (clk),
      .reset      (reset),
      .flush      (ifid_flush),
      .hold       (stall),
      .instr_in   (imem_rdata),
      .pc_plus4_in(pc_plus4),
      .instr      (if_id_instr),
      .pc_plus4   (if_id_pc_plus4),
      .valid      (if_id_valid)
   );

   always_ff @(posedge clk) begin
      if (reset)
         fetch_count <= '0;
      else if (ifid_load_valid && (fetch_count != '1))
         fetch_count <= fetch_count + 32'd1;
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: free run, stall, j, stalled jr, branch+stall
// collision, PC wrap and reset during stall.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic [1:0]  id_pcsrc;
   logic [31:0] id_rs_data;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rom [256];

   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr];

   if_stage #(
      .RESET_PC (32'h0000_0000),
      .IMEM_AW  (8),
      .NOP_INSTR(32'h0000_0000)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .ex_branch_taken (ex_branch_taken),
      .ex_branch_target(ex_branch_target),
      .id_pcsrc        (id_pcsrc),
      .id_rs_data      (id_rs_data),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .pc              (pc),
      .if_id_instr     (if_id_instr),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .if_id_valid     (if_id_valid),
      .fetch_count     (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; ex_branch_taken = 1'b0;
      ex_branch_target = '0; id_pcsrc = 2'b01; id_rs_data = '0;
      for (int i = 0; i < 3; i++) step();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
      n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr: got %h want 00", imem_addr); end
      reset = 1'b0;
   endtask

   task automatic test_free_run();
      step();
      n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL run1_pc: got %h want %h", pc, 32'h4); end
      n_checks++; if (if_id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL run1_pp4: got %h want %h", if_id_pc_plus4, 32'h4); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL run1_valid: got %b want 1", if_id_valid); end
      n_checks++; if (if_id_instr !== 32'h2000_0000) begin n_fail++; $display("FAIL run1_instr: got %h want %h", if_id_instr, 32'h2000_0000); end
      n_checks++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL run1_count: got %0d want 1", fetch_count); end
      step();
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL run2_pc: got %h want %h", pc, 32'h8); end
      n_checks++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL run2_pp4: got %h want %h", if_id_pc_plus4, 32'h8); end
      n_checks++; if (if_id_instr !== 32'h2000_0001) begin n_fail++; $display("FAIL run2_instr: got %h want %h", if_id_instr, 32'h2000_0001); end
      n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL run2_count: got %0d want 2", fetch_count); end
      n_checks++; if (imem_addr !== 8'h02) begin n_fail++; $display("FAIL run2_imem_addr: got %h want 02", imem_addr); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 32'h8); end
         n_checks++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stall_pp4[%0d]: got %h want %h", i, if_id_pc_plus4, 32'h8); end
         n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, if_id_valid); end
         n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); end
      end
      stall = 1'b0;
      step();
      n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL unstall_pc: got %h want %h", pc, 32'hC); end
      n_checks++; if (if_id_pc_plus4 !== 32'hC) begin n_fail++; $display("FAIL unstall_pp4: got %h want %h", if_id_pc_plus4, 32'hC); end
      n_checks++; if (if_id_instr !== 32'h2000_0002) begin n_fail++; $display("FAIL unstall_instr: got %h want %h", if_id_instr, 32'h2000_0002); end
      n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL unstall_count: got %0d want 3", fetch_count); end
   endtask

   task automatic test_jump();
      step();
      step();
      n_checks++; if (if_id_instr !== 32'h0800_0040) begin n_fail++; $display("FAIL j_ifid_instr: got %h want %h", if_id_instr, 32'h0800_0040); end
      n_checks++; if (if_id_pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL j_ifid_pp4: got %h want %h", if_id_pc_plus4, 32'h14); end
      id_pcsrc = 2'b10;
      step();
      id_pcsrc = 2'b01;
      n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL j_pc: got %h want %h", pc, 32'h100); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL j_bubble_instr: got %h want %h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL j_bubble_valid: got %b want 0", if_id_valid); end
      n_checks++; if (fetch_count !== 32'd5) begin n_fail++; $display("FAIL j_count: got %0d want 5", fetch_count); end
      step();
      n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL j_after_pc: got %h want %h", pc, 32'h104); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL j_after_valid: got %b want 1", if_id_valid); end
      n_checks++; if (if_id_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL j_after_pp4: got %h want %h", if_id_pc_plus4, 32'h104); end
      n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL j_after_count: got %0d want 6", fetch_count); end
   endtask

   task automatic test_jr_stall();
      id_pcsrc = 2'b11; id_rs_data = 32'h203; stall = 1'b1;
      step();
      n_checks++; if (pc !== 32'h104) begin n_fail++; $display("FAIL jr_stall_pc: got %h want %h", pc, 32'h104); end
      n_checks++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL jr_stall_valid: got %b want 1", if_id_valid); end
      stall = 1'b0; id_rs_data = 32'h200;
      step();
      id_pcsrc = 2'b01; id_rs_data = '0;
      n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jr_pc: got %h want %h", pc, 32'h200); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL jr_bubble_valid: got %b want 0", if_id_valid); end
      n_checks++; if (fetch_count !== 32'd6) begin n_fail++; $display("FAIL jr_count: got %0d want 6", fetch_count); end
      step();
      n_checks++; if (pc !== 32'h204) begin n_fail++; $display("FAIL jr_after_pc: got %h want %h", pc, 32'h204); end
      n_checks++; if (if_id_instr !== 32'h2000_0080) begin n_fail++; $display("FAIL jr_after_instr: got %h want %h", if_id_instr, 32'h2000_0080); end
      n_checks++; if (fetch_count !== 32'd7) begin n_fail++; $display("FAIL jr_after_count: got %0d want 7", fetch_count); end
   endtask

   task automatic test_branch_collision();
      ex_branch_taken = 1'b1; ex_branch_target = 32'h40; stall = 1'b1; id_pcsrc = 2'b10;
      step();
      ex_branch_taken = 1'b0; ex_branch_target = '0; stall = 1'b0; id_pcsrc = 2'b01;
      n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_pc: got %h want %h", pc, 32'h40); end
      n_checks++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h want %h", if_id_instr, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
      n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL br_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
      n_checks++; if (fetch_count !== 32'd7) begin n_fail++; $display("FAIL br_count: got %0d want 7", fetch_count); end
      step();
      n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL br_after_pc: got %h want %h", pc, 32'h44); end
      n_checks++; if (if_id_instr !== 32'h2000_0010) begin n_fail++; $display("FAIL br_after_instr: got %h want %h", if_id_instr, 32'h2000_0010); end
      n_checks++; if (fetch_count !== 32'd8) begin n_fail++; $display("FAIL br_after_count: got %0d want 8", fetch_count); end
   endtask

   task automatic test_wrap_and_reset();
      ex_branch_taken = 1'b1; ex_branch_target = 32'hFFFF_FFFC;
      step();
      ex_branch_taken = 1'b0; ex_branch_target = '0;
      n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
      n_checks++; if (imem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_top_imem_addr: got %h want ff", imem_addr); end
      step();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
      n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_imem_addr: got %h want 00", imem_addr); end
      n_checks++; if (if_id_instr !== 32'h2000_00FF) begin n_fail++; $display("FAIL wrap_instr: got %h want %h", if_id_instr, 32'h2000_00FF); end
      n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
      n_checks++; if (fetch_count !== 32'd9) begin n_fail++; $display("FAIL wrap_count: got %0d want 9", fetch_count); end
      step();
      step();
      stall = 1'b1;
      step();
      n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL prereset_pc: got %h want %h", pc, 32'h8); end
      reset = 1'b1;
      step();
      reset = 1'b0; stall = 1'b0;
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL midreset_pc: got %h want %h", pc, 32'h0); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", if_id_valid); end
      n_checks++; if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL midreset_pp4: got %h want %h", if_id_pc_plus4, 32'h0); end
      n_checks++; if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL midreset_count: got %0d want 0", fetch_count); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 | i;
      rom[4] = 32'h0800_0040;
      test_reset();
      test_free_run();
      test_stall();
      test_jump();
      test_jr_stall();
      test_branch_collision();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
